m_011: RTL and testbench
========================

Name: m_011

Overview:
- Moore-type serial sequence detector that asserts `y` when the last three sampled bits of serial input `x` were 0, 1, 1, in that order.
- Samples one bit per rising clock edge.
- Sits on a serial bit stream as a pattern-match flag generator; `y` drives downstream control logic directly from state.

Parameters:
- none (sequence fixed as 0-1-1; state encoding internal)

Ports:
- clk   input   1  system clock; all state updates on rising edge
- nrst  input   1  reset, asynchronous, active-low; clears FSM to idle
- x     input   1  serial data bit, sampled on rising edge of clk
- y     output  1  detect flag; 1 while FSM is in the "matched 011" state

Behaviour:
- One clock; reset is asynchronous and active-low (nrst). Asserting nrst low immediately forces state S0 and y=0, independent of clk. Deassertion is synchronous to next rising edge in effect: the first sample is taken at the first rising edge with nrst=1.
- States, 2-bit registered encoding:
  - S0 = 00, idle / no useful prefix.
  - S1 = 01, seen "0".
  - S2 = 10, seen "01".
  - S3 = 11, seen "011", detect.
- Transitions on rising clk when nrst=1 (x=0 / x=1):
  - S0: ->S1 / ->S0
  - S1: ->S1 / ->S2
  - S2: ->S1 / ->S3
  - S3: ->S1 / ->S0
- Output is Moore: y = 1 iff state == S3, else 0. No combinational path from x to y.
- Latency: y rises in the same clock edge that samples the final '1' of "011". y is visible for exactly one cycle unless the pattern recurs.
- Overlap: after S3, an x=0 is reused as the start of a new "011" (S3->S1). Minimum spacing between detects is therefore 3 cycles, with y high every third cycle for a repeating 011011…
- Runs of 1 after a detect (0111) do not re-detect; the fourth bit returns to S0.
- Runs of 0 keep the FSM in S1.
- Reset mid-operation, including while y=1, drops y to 0 asynchronously and discards any partial match.
- No illegal states exist (all four encodings used); the default branch goes to S0.
- State register and y are the only storage; y may be decoded from state or separately registered, provided the timing above holds.

Test Plan:
- Reset: hold nrst=0 with x toggling over several edges -> y=0, state S0 throughout. Release nrst -> first edge with x=0 goes to S1, y=0.
- Basic detect: nrst=1, x stream 0,0,1,1,0 on successive edges -> y = 0,0,0,1,0. y is high exactly one cycle, after the edge sampling the second '1'.
- False prefixes: x = 0,1,0,1,1,0 -> y only after the 5th edge (0,0,0,0,1,0). Also 1,1,1 from reset -> y stays 0.
- Overlap/back-to-back: x = 0,1,1,0,1,1,0,1,1 -> y = 1 after edges 3, 6 and 9, and 0 elsewhere. Then x=1 -> state S0, y=0.
- Full stream: from reset, x per edge = 0,0,1,1,0,1,0,1,1,0,0,1,1,0,1,1,1 -> y high only after edges 4, 9, 13 and 16, and 0 after edge 17.
- Async reset mid-detect: while y=1, pulse nrst low between clock edges -> y falls immediately, not at the next edge. After release, x=1,1 gives no detect; 0,1,1 does.

Source files
------------

// File: rtl/m_011.sv
// Moore serial detector for the bit sequence 0-1-1 on input x.
// y is a registered flag that is high while the "011" match state is held.
module m_011 (
  input  logic clk,
  input  logic nrst,
  input  logic x,
  output logic y
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   y_r;

  // Next-state decode; a 0 always restarts a match so overlapping patterns are caught.
  always_comb begin
    next_state_s = S0;
    case (state_r)
      S0: begin
        if (x == 1'b0) begin
          next_state_s = S1;
        end else begin
          next_state_s = S0;
        end
      end
      S1: begin
        if (x == 1'b0) begin
          next_state_s = S1;
        end else begin
          next_state_s = S2;
        end
      end
      S2: begin
        if (x == 1'b0) begin
          next_state_s = S1;
        end else begin
          next_state_s = S3;
        end
      end
      S3: begin
        if (x == 1'b0) begin
          next_state_s = S1;
        end else begin
          next_state_s = S0;
        end
      end
      default: begin
        next_state_s = S0;
      end
    endcase
  end

  // State and detect flag; y_r tracks entry into S3 so it equals (state_r == S3).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= S0;
      y_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      y_r     <= (next_state_s == S3) ? 1'b1 : 1'b0;
    end
  end

  assign y = y_r;

endmodule

// File: tb/tb_m_011.sv
// Self-checking bench for m_011: directed streams plus random bits and async reset pulses,
// checked against a "last three bits since reset equal 011" history model.
module tb_m_011;

  logic clk;
  logic nrst;
  logic x;
  logic y;

  int n_checks;
  int n_errors;

  // Reference model: bit history since last reset.
  logic [2:0] hist;
  int         nbits;
  logic       exp_y;

  m_011 dut (
    .clk  (clk),
    .nrst (nrst),
    .x    (x),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic void model_reset();
    hist  = 3'b000;
    nbits = 0;
    exp_y = 1'b0;
  endfunction

  function automatic void model_push(input logic b);
    hist  = {hist[1:0], b};
    nbits = nbits + 1;
    exp_y = (nbits >= 3) && (hist == 3'b011);
  endfunction

  // Drive one bit, let it be sampled, then compare y shortly after the edge.
  task automatic step(input string tag, input logic b);
    x = b;
    @(posedge clk);
    #1;
    model_push(b);
    chk(tag, y, exp_y);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #1;
    nrst = 1'b0;
    #1;
    chk(tag, y, 1'b0);
    model_reset();
    #1;
    nrst = 1'b1;
  endtask

  task automatic run_stream(input string tag, input logic [31:0] bits, input int len);
    logic [31:0] v;
    v = bits;
    for (int i = len - 1; i >= 0; i--) begin
      step(tag, v[i]);
    end
  endtask

  int detects;

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    nrst = 1'b0;
    x    = 1'b0;

    // Reset held with x toggling over several edges.
    #2;
    chk("rst_y", y, 1'b0);
    for (int i = 0; i < 6; i++) begin
      x = (i % 2 == 0) ? 1'b0 : 1'b1;
      if (i == 3) x = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_hold", y, 1'b0);
    end
    nrst = 1'b1;

    // Basic detect 0,0,1,1,0 -> y 0,0,0,1,0.
    step("basic0", 1'b0);
    chk("basic0_const", y, 1'b0);
    step("basic1", 1'b0);
    step("basic2", 1'b1);
    step("basic3", 1'b1);
    chk("basic3_const", y, 1'b1);
    step("basic4", 1'b0);
    chk("basic4_const", y, 1'b0);

    // False prefix 0,1,0,1,1,0 then 1,1,1 from reset.
    pulse_reset("rst_fp");
    run_stream("falsepfx", 32'b010110, 6);
    pulse_reset("rst_111");
    run_stream("ones", 32'b111, 3);
    chk("ones_const", y, 1'b0);

    // Overlapping back-to-back detects, then a trailing 1.
    pulse_reset("rst_ovl");
    run_stream("overlap", 32'b011011011, 9);
    chk("overlap_last", y, 1'b1);
    step("overlap_tail", 1'b1);
    chk("overlap_tail_const", y, 1'b0);

    // Full stream: detects after edges 4, 9, 13, 16 only.
    pulse_reset("rst_full");
    detects = 0;
    begin
      logic [16:0] fs;
      fs = 17'b00110101100110111;
      for (int i = 16; i >= 0; i--) begin
        step("full", fs[i]);
        if (y === 1'b1) detects++;
      end
    end
    chk("full_last", y, 1'b0);
    chk("full_cnt4", (detects == 4) ? 1'b1 : 1'b0, 1'b1);

    // Async reset while y is high, then 1,1 (no detect) and 0,1,1 (detect).
    pulse_reset("rst_pre");
    run_stream("pre", 32'b011, 3);
    chk("pre_high", y, 1'b1);
    pulse_reset("async_mid");
    run_stream("post11", 32'b11, 2);
    chk("post11_const", y, 1'b0);
    run_stream("post011", 32'b011, 3);
    chk("post011_const", y, 1'b1);

    // Random bits with occasional async reset pulses.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset("rand_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
